// File: rtl/board_store.sv
// Playfield tile store: single-tile write/read ports, flattened board output and a line-clear sweep engine.
// Optional feature macro LINES_TOTAL_EN adds lines_total_o, a saturating lifetime count of removed rows.
module board_store #(
   parameter int COLS = 10,
   parameter int ROWS = 20,
   parameter int TW = 8,
   parameter logic [TW-1:0] EMPTY = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   input  logic                      sweep_i,
   input  logic                      wr_en_i,
   input  logic [3:0]                wr_col_i,
   input  logic [4:0]                wr_row_i,
   input  logic [TW-1:0]             wr_tile_i,
   input  logic [3:0]                rd_col_i,
   input  logic [4:0]                rd_row_i,
   output logic [TW-1:0]             rd_tile_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [4:0]                lines_o,
`ifdef LINES_TOTAL_EN
   output logic [15:0]               lines_total_o,
`endif
   output logic [0:COLS*ROWS*TW-1]   tiles_o
);

   typedef logic [COLS-1:0][TW-1:0] row_t;
   typedef enum logic [2:0] {IDLE, CLEAR, SCAN, SHIFT, DONE} state_t;

   localparam logic [3:0] COLS_W    = 4'(COLS);
   localparam logic [4:0] ROWS_W    = 5'(ROWS);
   localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
   localparam row_t       EMPTY_ROW = {COLS{EMPTY}};

   state_t        state_q, state_d;
   row_t          board_q [ROWS];
   row_t          board_d [ROWS];
   logic [4:0]    row_q, row_d;
   logic [4:0]    shift_q, shift_d;
   logic [4:0]    lines_q, lines_d;
   logic [TW-1:0] rd_tile_q, rd_tile_d;
   logic [4:0]    shiftAbove;
   logic          wrInRange;
   logic          rdInRange;
   logic          scanFull;
`ifdef LINES_TOTAL_EN
   logic [15:0]   total_q, total_d;
`endif

   function automatic logic rowFull(input row_t row);
      rowFull = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (row[c] == EMPTY) rowFull = 1'b0;
      end
   endfunction

   assign wrInRange  = (wr_col_i < COLS_W) && (wr_row_i < ROWS_W);
   assign rdInRange  = (rd_col_i < COLS_W) && (rd_row_i < ROWS_W);
   assign scanFull   = (state_q == SCAN) && rowFull(board_q[row_q]);
   assign shiftAbove = shift_q - 5'd1;

   // row_q walks top-down while clearing and bottom-up while scanning;
   // shift_q is the destination row of the current shift pass.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      shift_d = shift_q;
      lines_d = lines_q;
      board_d = board_q;
      unique case (state_q)
         IDLE: begin
            if (wr_en_i && wrInRange) board_d[wr_row_i][wr_col_i] = wr_tile_i;
            if (clear_i) begin
               state_d = CLEAR;
               row_d   = '0;
            end else if (sweep_i) begin
               state_d = SCAN;
               row_d   = LAST_ROW;
               lines_d = '0;
            end
         end
         CLEAR: begin
            board_d[row_q] = EMPTY_ROW;
            if (row_q == LAST_ROW) state_d = DONE;
            else                   row_d   = row_q + 5'd1;
         end
         SCAN: begin
            if (scanFull) begin
               if (lines_q < ROWS_W) lines_d = lines_q + 5'd1;
               shift_d = row_q;
               state_d = SHIFT;
            end else if (row_q == '0) begin
               state_d = DONE;
            end else begin
               row_d = row_q - 5'd1;
            end
         end
         SHIFT: begin
            // Returning to SCAN keeps row_q so the row pulled down gets re-tested.
            if (shift_q == '0) begin
               board_d[0] = EMPTY_ROW;
               state_d    = SCAN;
            end else begin
               board_d[shift_q] = board_q[shiftAbove];
               shift_d          = shiftAbove;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Reading from the next-state board lets a same-cycle write show up on rd_tile_o.
   always_comb begin
      rd_tile_d = EMPTY;
      if (rdInRange) rd_tile_d = board_d[rd_row_i][rd_col_i];
   end

`ifdef LINES_TOTAL_EN
   always_comb begin
      total_d = total_q;
      if (scanFull && (total_q != 16'hFFFF)) total_d = total_q + 16'd1;
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         row_q     <= '0;
         shift_q   <= '0;
         lines_q   <= '0;
         rd_tile_q <= EMPTY;
         for (int r = 0; r < ROWS; r++) board_q[r] <= EMPTY_ROW;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         shift_q   <= shift_d;
         lines_q   <= lines_d;
         rd_tile_q <= rd_tile_d;
         board_q   <= board_d;
      end
   end

`ifdef LINES_TOTAL_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) total_q <= '0;
      else       total_q <= total_d;
   end

   assign lines_total_o = total_q;
`endif

   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            tiles_o[(r*COLS + c)*TW +: TW] = board_q[r][c];
         end
      end
   end

   assign rd_tile_o = rd_tile_q;
   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);
   assign lines_o   = lines_q;

endmodule
